flow_scheduler: RTL and testbench

FLOW_SCHEDULER -- requirements
Module: flow_scheduler

---
 rtl/flow_scheduler.sv | 127 ++++++++++++
 tb/tb_flow_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flow_scheduler.sv
// Dependency-driven task sequencer: launches ready tasks (all predecessors done)
// lowest index first, at most MAX_ACTIVE in flight, and reports completion or deadlock.
module flow_scheduler #(
  parameter int NUM_TASKS  = 8,
  parameter int MAX_ACTIVE = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_TASKS)-1:0] cfg_idx,
  input  logic [NUM_TASKS-1:0]         cfg_deps,
  input  logic                         run_start,
  input  logic [NUM_TASKS-1:0]         task_done,
  output logic [NUM_TASKS-1:0]         task_start,
  output logic                         busy,
  output logic                         run_done,
  output logic                         run_error,
  output logic [NUM_TASKS-1:0]         done_mask,
  output logic                         spurious
);

  localparam int              CNT_W   = $clog2(MAX_ACTIVE + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ACTIVE);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]           state;
  logic [NUM_TASKS-1:0] dep [NUM_TASKS];
  logic [NUM_TASKS-1:0] active;
  logic [CNT_W-1:0]     count;

  logic [NUM_TASKS-1:0] ready;
  logic [NUM_TASKS-1:0] lowest;
  logic [NUM_TASKS-1:0] launch;
  logic [NUM_TASKS-1:0] valid_done;
  logic [CNT_W-1:0]     n_done;
  logic                 any_ready;
  logic                 all_done;
  logic                 can_launch;
  logic                 deadlock;

  // Readiness looks only at the registered done_mask, so a completion at edge t
  // unblocks its dependants no earlier than edge t+1.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // assignment; otherwise a missed path infers a latch.
    ready = '0;
    for (int i = 0; i < NUM_TASKS; i++) begin
      ready[i] = !done_mask[i] && !active[i] && ((dep[i] & ~done_mask) == '0);
    end
  end

  // Isolate the lowest set bit: x & -x.
  assign lowest     = ready & (~ready + NUM_TASKS'(1));
  assign any_ready  = |ready;
  assign all_done   = &done_mask;
  assign can_launch = (state == S_RUN) && (count < MAX_CNT) && any_ready;
  assign launch     = can_launch ? lowest : '0;
  assign valid_done = (state == S_RUN) ? (task_done & active) : '0;
  assign deadlock   = (state == S_RUN) && !all_done && (count == '0) && !any_ready;

  always_comb begin
    // NOTE: combinational logic uses blocking '=' so the running sum accumulates
    // within the block; registers below use non-blocking '<=' exclusively.
    n_done = '0;
    for (int i = 0; i < NUM_TASKS; i++) begin
      n_done = n_done + CNT_W'(valid_done[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      // NOTE: the dependency table is an observable configuration memory and
      // must come out of reset with every task independent, so it is cleared.
      for (int i = 0; i < NUM_TASKS; i++) begin
        dep[i] <= '0;
      end
      done_mask  <= '0;
      active     <= '0;
      count      <= '0;
      task_start <= '0;
      run_error  <= 1'b0;
      spurious   <= 1'b0;
    end else begin
      task_start <= launch;
      run_error  <= deadlock;
      // Any completion pulse not accepted against an active task is spurious.
      if ((task_done & ~valid_done) != '0) begin
        spurious <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (cfg_we && (int'(cfg_idx) < NUM_TASKS)) begin
            dep[cfg_idx] <= cfg_deps;
          end
          if (run_start) begin
            done_mask <= '0;
            active    <= '0;
            count     <= '0;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          done_mask <= done_mask | valid_done;
          active    <= (active & ~valid_done) | launch;
          count     <= count + CNT_W'(can_launch) - n_done;
          if (all_done) begin
            state <= S_FIN;
          end else if (deadlock) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = (state != S_IDLE);
  assign run_done = (state == S_FIN);

endmodule

// File: tb/tb_flow_scheduler.sv
// Bench for flow_scheduler: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a set-based behavioural model.
module tb_flow_scheduler;

  localparam int N  = 4;
  localparam int MA = 2;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         cfg_we    = 1'b0;
  logic [1:0]   cfg_idx   = '0;
  logic [N-1:0] cfg_deps  = '0;
  logic         run_start = 1'b0;
  logic [N-1:0] auto_td   = '0;
  logic [N-1:0] man_td    = '0;
  logic [N-1:0] task_done;
  logic [N-1:0] task_start;
  logic [N-1:0] done_mask;
  logic         busy;
  logic         run_done;
  logic         run_error;
  logic         spurious;

  assign task_done = auto_td | man_td;

  always #5 clk = ~clk;

  flow_scheduler #(.NUM_TASKS(N), .MAX_ACTIVE(MA)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_deps   (cfg_deps),
    .run_start  (run_start),
    .task_done  (task_done),
    .task_start (task_start),
    .busy       (busy),
    .run_done   (run_done),
    .run_error  (run_error),
    .done_mask  (done_mask),
    .spurious   (spurious)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: sets of done/active tasks, recomputed per clock edge.
  int           m_phase = 0;   // 0 idle, 1 running, 2 finishing
  logic [N-1:0] m_dep [N] = '{default: '0};
  logic [N-1:0] m_done   = '0;
  logic [N-1:0] m_active = '0;
  logic [N-1:0] m_start  = '0;
  logic         m_err    = 1'b0;
  logic         m_spur   = 1'b0;

  always @(posedge clk) begin : model_step
    int           pick;
    int           n_act;
    logic [N-1:0] nd;
    logic [N-1:0] na;
    if (rst) begin
      m_phase  = 0;
      for (int i = 0; i < N; i++) m_dep[i] = '0;
      m_done   = '0;
      m_active = '0;
      m_start  = '0;
      m_err    = 1'b0;
      m_spur   = 1'b0;
    end else begin
      m_err   = 1'b0;
      m_start = '0;
      case (m_phase)
        0: begin
          if (task_done != '0) m_spur = 1'b1;
          if (cfg_we) m_dep[cfg_idx] = cfg_deps;
          if (run_start) begin
            m_done   = '0;
            m_active = '0;
            m_phase  = 1;
          end
        end
        1: begin
          n_act = $countones(m_active);
          pick  = -1;
          if (n_act < MA) begin
            for (int i = N - 1; i >= 0; i--) begin
              if (!m_done[i] && !m_active[i] && ((m_dep[i] & ~m_done) == '0)) pick = i;
            end
          end
          nd = m_done;
          na = m_active;
          for (int i = 0; i < N; i++) begin
            if (task_done[i]) begin
              if (m_active[i]) begin
                nd[i] = 1'b1;
                na[i] = 1'b0;
              end else begin
                m_spur = 1'b1;
              end
            end
          end
          if (m_done == '1) begin
            m_phase = 2;
          end else if (n_act == 0 && pick < 0) begin
            m_phase = 0;
            m_err   = 1'b1;
          end else if (pick >= 0) begin
            na[pick]      = 1'b1;
            m_start[pick] = 1'b1;
          end
          m_done   = nd;
          m_active = na;
        end
        default: begin
          if (task_done != '0) m_spur = 1'b1;
          m_phase = 0;
        end
      endcase
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_task_start", task_start, m_start);
      check("model_busy",       busy,       m_phase != 0);
      check("model_run_done",   run_done,   m_phase == 2);
      check("model_run_error",  run_error,  m_err);
      check("model_done_mask",  done_mask,  m_done);
      check("model_spurious",   spurious,   m_spur);
    end
  end

  // Task responder: answers each launch after a fixed or random latency.
  bit auto_on   = 1'b0;
  int fixed_lat = 1;
  int rem [N]   = '{default: -1};

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) rem[i] = -1;
      else if (task_start[i] && auto_on)
        rem[i] = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      auto_td[i] = 1'b0;
      if (auto_on && rem[i] == 0) begin
        auto_td[i] = 1'b1;
        rem[i]     = -1;
      end else if (rem[i] > 0) begin
        rem[i]--;
      end
    end
  end

  int start_log[$];
  int run_done_cnt = 0;

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) if (task_start[i]) start_log.push_back(i);
    if (run_done) run_done_cnt++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cfg(int idx, logic [N-1:0] d);
    cfg_we   = 1'b1;
    cfg_idx  = 2'(idx);
    cfg_deps = d;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic start_run();
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
  endtask

  task automatic wait_idle(string name, int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    check({name, "_timeout"}, busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int           rdc0;
    logic [N-1:0] r;
    logic [N-1:0] low;

    // Reset state
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_busy",       busy,       1'b0);
    check("rst_task_start", task_start, 4'b0000);
    check("rst_done_mask",  done_mask,  4'b0000);
    check("rst_spurious",   spurious,   1'b0);
    check("rst_run_done",   run_done,   1'b0);
    check("rst_run_error",  run_error,  1'b0);
    rst = 1'b0;
    tick();

    // Chain t0 -> t1 -> t2 -> t3, each done one cycle after its start
    cfg(1, 4'b0001);
    cfg(2, 4'b0010);
    cfg(3, 4'b0100);
    auto_on   = 1'b1;
    fixed_lat = 1;
    start_log.delete();
    rdc0 = run_done_cnt;
    start_run();
    check("chain_busy_c1",  busy,       1'b1);
    check("chain_start_c1", task_start, 4'b0000);
    tick();
    check("chain_first_start", task_start, 4'b0001);
    wait_idle("chain", 60);
    check("chain_n_starts", start_log.size(), 4);
    if (start_log.size() == 4) begin
      for (int i = 0; i < 4; i++) check("chain_order", start_log[i], i);
    end
    check("chain_done_mask", done_mask, 4'b1111);
    check("chain_run_done_once", run_done_cnt - rdc0, 1);
    repeat (3) tick();
    check("chain_mask_held", done_mask, 4'b1111);

    // Fan-out: four independent tasks, MAX_ACTIVE=2, no completions at first
    cfg(1, 4'b0000);
    cfg(2, 4'b0000);
    cfg(3, 4'b0000);
    auto_on = 1'b0;
    start_run();
    tick();
    check("fan_c2", task_start, 4'b0001);
    tick();
    check("fan_c3", task_start, 4'b0010);
    tick();
    check("fan_c4", task_start, 4'b0000);
    tick();
    check("fan_c5", task_start, 4'b0000);
    man_td = 4'b0001;
    tick();
    man_td = 4'b0000;
    check("fan_c6", task_start, 4'b0000);
    tick();
    check("fan_t2_after_done", task_start, 4'b0100);
    man_td    = 4'b0110;
    auto_on   = 1'b1;
    fixed_lat = 0;
    tick();
    man_td = 4'b0000;
    wait_idle("fan", 40);
    check("fan_done_mask", done_mask, 4'b1111);

    // Dependency cycle t0 <-> t1, others behind t0
    cfg(0, 4'b0010);
    cfg(1, 4'b0001);
    cfg(2, 4'b0001);
    cfg(3, 4'b0001);
    start_run();
    check("cyc_busy_c1",  busy,       1'b1);
    check("cyc_err_c1",   run_error,  1'b0);
    tick();
    check("cyc_err_c2",   run_error,  1'b1);
    check("cyc_busy_c2",  busy,       1'b0);
    check("cyc_no_start", task_start, 4'b0000);
    tick();
    check("cyc_err_c3",   run_error,  1'b0);

    // Zero-latency completion of t0 in its own start cycle
    cfg(0, 4'b0000);
    cfg(1, 4'b0001);
    cfg(2, 4'b0010);
    cfg(3, 4'b0100);
    auto_on   = 1'b1;
    fixed_lat = 0;
    start_run();
    tick();
    check("zl_start_t0", task_start, 4'b0001);
    tick();
    check("zl_done_t0",  done_mask,  4'b0001);
    tick();
    check("zl_start_t1", task_start, 4'b0010);
    wait_idle("zl", 40);
    check("zl_done_mask", done_mask, 4'b1111);
    check("zl_no_spurious", spurious, 1'b0);

    // Reset mid-run with t1 active
    auto_on = 1'b0;
    cfg(1, 4'b0000);
    cfg(2, 4'b0000);
    cfg(3, 4'b0000);
    start_run();
    tick();
    tick();
    check("mr_t1_started", task_start, 4'b0010);
    rst = 1'b1;
    tick();
    check("mr_task_start", task_start, 4'b0000);
    check("mr_busy",       busy,       1'b0);
    check("mr_run_done",   run_done,   1'b0);
    check("mr_run_error",  run_error,  1'b0);
    check("mr_done_mask",  done_mask,  4'b0000);
    check("mr_spurious",   spurious,   1'b0);
    rst    = 1'b0;
    man_td = 4'b0010;
    tick();
    man_td = 4'b0000;
    check("mr_late_done_spurious", spurious, 1'b1);
    auto_on   = 1'b1;
    fixed_lat = -1;
    start_run();
    check("mr_rerun_mask_empty", done_mask, 4'b0000);
    wait_idle("mr_rerun", 60);
    check("mr_rerun_done_mask", done_mask, 4'b1111);
    check("mr_spurious_sticky", spurious,  1'b1);

    // Randomized traffic, checked by the model every cycle
    auto_on   = 1'b1;
    fixed_lat = -1;
    for (int c = 0; c < 4000; c++) begin
      cfg_we    = ($urandom_range(0, 5) == 0);
      cfg_idx   = 2'($urandom_range(0, N - 1));
      r         = N'($urandom);
      low       = N'((1 << cfg_idx) - 1);
      cfg_deps  = ($urandom_range(0, 7) == 0) ? r : (r & low);
      run_start = ($urandom_range(0, 9) == 0);
      man_td    = ($urandom_range(0, 60) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
      rst       = ($urandom_range(0, 400) == 0);
      tick();
    end
    cfg_we    = 1'b0;
    run_start = 1'b0;
    man_td    = '0;
    rst       = 1'b0;
    tick();
    wait_idle("random_drain", 200);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
